// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl
// Purpose  : Load/store unit controller. Accepts one decoded load or store
//            from the core, stalls the pipeline, runs a single request/grant
//            (and for loads, read-valid) handshake on the data bus, performs
//            byte-lane steering and load extension, and writes the load
//            result back to the register file. Bad encodings and bus
//            timeouts end in a one-cycle error pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT     max cycles spent in REQ plus WAIT before a bus error (1..255)
// Ports
//   clk, rst            core clock, asynchronous active-high reset
//   start, is_store     load/store valid (held while stall=1), store select
//   funct3, addr        access size/sign, effective byte address
//   wdata, rd           store data, load destination register
//   stall               freezes PC and instruction register
//   mem_req, mem_we     bus request, write strobe
//   mem_addr, mem_be    word-aligned address, byte lane enables
//   mem_wdata           lane-replicated store data
//   mem_gnt, mem_rvalid request accepted, read data valid
//   mem_rdata           read data
//   wb_wen/addr/data    register-file write port for loads
//   err, misalign       one-cycle error pulses
// Build option
//   LSU_MISALIGN_TRAP_EN  when defined, misaligned H/HU/W accesses trap
//                         (err and misalign pulse) instead of truncating the
//                         low address bits.
// ============================================================================
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_wen,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        err,
  output logic        misalign
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  // Last counter value at which the transaction may still complete.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic        st_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [4:0]  rd_q;
  logic [31:0] res_q;

  logic        bad_f3;
  logic        misal;
  logic        timeout;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // 011/11x are never legal; 1xx is only legal as an unsigned load.
  assign bad_f3  = (f3_q[1:0] == 2'b11) || (f3_q[2] && (st_q || f3_q[1]));
  assign timeout = (cnt >= CNT_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misal = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                 ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  // Lane enables and replicated store data; low address bits below the
  // access size are simply ignored when misalignment is not trapped.
  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be        = 4'b0001 << addr_q[1:0];
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be        = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata_q;
      end
    endcase
  end

  // Lane select and sign/zero extension of the returned word.
  always_comb begin
    ld_byte = mem_rdata[8*addr_q[1:0] +: 8];
    ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   ld_data = {{24{ld_byte[7] & ~f3_q[2]}}, ld_byte};
      2'b01:   ld_data = {{16{ld_half[15] & ~f3_q[2]}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 8'd0;
      st_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rd_q    <= 5'd0;
      res_q   <= 32'd0;
    end else begin
      if (state == S_IDLE && start) begin
        st_q    <= is_store;
        f3_q    <= funct3;
        addr_q  <= addr;
        wdata_q <= wdata;
        rd_q    <= rd;
        cnt     <= 8'd0;
      end else if (state == S_REQ || state == S_WAIT) begin
        cnt <= cnt + 8'd1;
      end
      if (state == S_WAIT && mem_rvalid) begin
        res_q <= ld_data;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    mem_req   = 1'b0;
    wb_wen    = 1'b0;
    wb_addr   = 5'd0;
    wb_data   = 32'd0;
    err       = 1'b0;
    misalign  = 1'b0;
    case (state)
      S_IDLE: begin
        // Gated by rst so the stall drops the instant reset is applied,
        // even while the core keeps start asserted.
        stall = start & ~rst;
        if (start) state_nxt = S_REQ;
      end
      S_REQ: begin
        stall = 1'b1;
        if (bad_f3 || misal) begin
          state_nxt = S_ERR;
        end else begin
          mem_req = 1'b1;
          if (mem_gnt)      state_nxt = st_q ? S_DONE : S_WAIT;
          else if (timeout) state_nxt = S_ERR;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (mem_rvalid)   state_nxt = S_DONE;
        else if (timeout) state_nxt = S_ERR;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        if (!st_q && rd_q != 5'd0) begin
          wb_wen  = 1'b1;
          wb_addr = rd_q;
          wb_data = res_q;
        end
      end
      S_ERR: begin
        state_nxt = S_IDLE;
        err       = 1'b1;
        misalign  = misal;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus attributes are only presented while a request is on the bus.
  assign mem_we    = mem_req & st_q;
  assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_be    = mem_req ? be : 4'd0;
  assign mem_wdata = (mem_req && st_q) ? wdata_rep : 32'd0;

endmodule
`default_nettype wire
